// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants for the FIFO read-side stream adapter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fifo_rd_stream_pkg;

  // Default word width; must match the FIFO being drained.
  localparam int DEF_DATA_WIDTH = 8;

  // The buffer must hold the in-flight word plus two stalled words,
  // so that requests never have to wait on the downstream handshake.
  localparam int BUF_DEPTH = 3;
  localparam int PTR_W     = 2;

  // Counter width needed to hold 0..n-1. Never returns less than 1.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Three-entry register FIFO holding words returned by the FIFO read port.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: none internally; the caller never pushes when full.
module stream_skid_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [1:0]            occ_o,
  output logic                  head_vld_o,
  output logic [DATA_WIDTH-1:0] head_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic                  pop_ok;

  // Pointers wrap at the buffer depth rather than at a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok      = pop_i & (occ_q != 2'd0);
  assign occ_o       = occ_q;
  assign head_vld_o  = (occ_q != 2'd0);
  assign head_data_o = head_vld_o ? mem_q[rd_ptr_q] : '0;

  // Next pointer and occupancy; simultaneous push and pop keep occupancy.
  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d    = occ_q;
    if (push_i && !pop_ok) occ_d = occ_q + 2'd1;
    if (!push_i && pop_ok) occ_d = occ_q - 2'd1;
  end

  // Storage and pointer registers; reset clears contents too.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the FIFO read port (req/empty, data one cycle later) into a framed valid/ready stream.
// Latency: 2 cycles from empty falling to m_valid_o; 1 word/cycle sustained.
// Backpressure: requests stop once buffered + in-flight words reach 3; nothing is dropped.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = 16,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  output logic                  fifo_r_req_o,
  input  logic                  fifo_r_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_r_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  busy_o
);

  localparam int              BEAT_W    = cnt_width(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  logic [1:0]        occ;
  logic [2:0]        level;
  logic              inflight_q, inflight_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              pop;

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (inflight_q),
    .push_data_i (fifo_r_data_i),
    .pop_i       (pop),
    .occ_o       (occ),
    .head_vld_o  (m_valid_o),
    .head_data_o (m_data_o)
  );

  // Words already committed to the buffer: stored plus the one still returning.
  assign level        = {1'b0, occ} + {2'b00, inflight_q};
  assign fifo_r_req_o = en_i & ~fifo_r_empty_i & (level <= 3'd2);
  assign pop          = m_valid_o & m_ready_i;
  assign m_last_o     = m_valid_o & (beat_q == BEAT_LAST);
  assign busy_o       = m_valid_o | inflight_q;

  // Burst position advances only on accepted words, so empty gaps keep it.
  always_comb begin
    inflight_d = fifo_r_req_o;
    beat_d     = beat_q;
    if (pop) beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + 1'b1;
  end

  // In-flight marker and burst counter; reset discards any returning word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inflight_q <= 1'b0;
      beat_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench: a queue-based source FIFO, a word-order/burst-position model and a monitor.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int BL = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          req;
  logic          empty = 1'b1;
  logic [DW-1:0] rdata = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;

  fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(BL), .BUF_DEPTH(3)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .en_i           (en),
    .fifo_r_req_o   (req),
    .fifo_r_empty_i (empty),
    .fifo_r_data_i  (rdata),
    .m_valid_o      (m_valid),
    .m_ready_i      (m_ready),
    .m_data_o       (m_data),
    .m_last_o       (m_last),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] src_q[$];
  exp_t          exp_q[$];
  int            exp_cnt = 0;
  int            level_q = 0;
  int            last_req_q = 0;
  int            req_cnt = 0;
  int            deliv_cnt = 0;
  int            n_total = 0;
  int            n_pass = 0;
  int            rmode = 0;
  int            pat_q = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  task automatic update_empty();
    empty = (src_q.size() == 0);
  endtask

  // Each loaded word's burst position is its index in the stream since reset.
  task automatic push_word(input logic [DW-1:0] d);
    exp_t e;
    e.d = d;
    e.l = ((exp_cnt % BL) == BL - 1);
    exp_cnt++;
    src_q.push_back(d);
    exp_q.push_back(e);
    update_empty();
  endtask

  task automatic clear_model();
    src_q.delete();
    exp_q.delete();
    exp_cnt = 0; level_q = 0; last_req_q = 0;
    req_cnt = 0; deliv_cnt = 0; prev_stall = 0;
    update_empty();
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && level_q == 0) begin ok = 1; break; end
    end
    check_eq("drain_done", ok, 1);
  endtask

  // Source FIFO: a request seen at an edge returns the next word just after it.
  // level_q counts words requested but not yet accepted downstream.
  always @(posedge clk) begin
    bit            req_e, pop_e;
    logic [DW-1:0] nxt;
    if (rst_n) begin
      req_e = req;
      pop_e = m_valid && m_ready;
      level_q = level_q + (req_e ? 1 : 0) - (pop_e ? 1 : 0);
      last_req_q = req_e ? 1 : 0;
      nxt = 8'hEE;
      if (req_e) begin
        req_cnt++;
        if (src_q.size() > 0) nxt = src_q.pop_front();
      end
      #1;
      if (req_e) rdata = nxt;
      update_empty();
    end
  end

  // Downstream ready patterns.
  always @(posedge clk) begin
    #1;
    pat_q++;
    case (rmode)
      0: m_ready = 1'b1;
      1: m_ready = ((pat_q % 4) == 0) || ((pat_q % 4) == 3);
      2: m_ready = ($urandom_range(0, 3) != 0);
      default: m_ready = 1'b0;
    endcase
  end

  // Monitor: handshake rules, request limits and scoreboard comparison.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check_eq("valid_vs_model", m_valid, (level_q - last_req_q) != 0);
      check_eq("busy_vs_model", busy, level_q != 0);
      if (req) begin
        check_eq("req_while_empty", empty, 0);
        check_eq("req_at_capacity", level_q <= 2, 1);
      end
      if (prev_stall) begin
        check_eq("stall_data_stable", m_data, prev_data);
        check_eq("stall_last_stable", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        check_eq("sb_word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("stream_data", m_data, e.d);
          check_eq("stream_last", m_last, e.l);
        end
        deliv_cnt++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  initial begin
    int pushed;
    // Reset values.
    #2;
    check_eq("rst_valid", m_valid, 0);
    check_eq("rst_data", m_data, 0);
    check_eq("rst_last", m_last, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_req", req, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    en = 1'b1;

    // Basic flow: 5 words, 2-cycle latency, back-to-back output.
    @(posedge clk); #2;
    for (int i = 1; i <= 5; i++) push_word(DW'(i));
    @(negedge clk);
    @(negedge clk); check_eq("lat_edge1_valid", m_valid, 0);
    @(negedge clk); check_eq("lat_edge2_valid", m_valid, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check_eq("consec_valid", m_valid, 1);
    end
    check_eq("busy_at_last_word", busy, 1);
    @(negedge clk); check_eq("busy_after_last_pop", busy, 0);
    wait_drain(20);

    // Burst framing: lasts on words 4 and 8; after 10 words the position is 2,
    // held across the gap, so words 11 and 12 close the third burst.
    do_reset();
    @(posedge clk); #2;
    for (int i = 0; i < 10; i++) push_word(DW'(8'h20 + i));
    wait_drain(40);
    repeat (20) @(posedge clk);
    #2;
    push_word(8'h2A);
    push_word(8'h2B);
    wait_drain(20);

    // Backpressure: ready 1-0-0-1 over 32 random words.
    do_reset();
    rmode = 1;
    @(posedge clk); #2;
    for (int i = 0; i < 32; i++) push_word(DW'($urandom_range(0, 255)));
    wait_drain(200);

    // Randomised trickle source with random ready.
    rmode = 2;
    pushed = 0;
    for (int i = 0; i < 400 && pushed < 60; i++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 1) == 1) begin
        push_word(DW'($urandom_range(0, 255)));
        pushed++;
      end
    end
    wait_drain(200);
    rmode = 0;

    // Empty boundary: a single word yields one request and one output.
    do_reset();
    @(posedge clk); #2;
    push_word(8'h77);
    repeat (10) @(negedge clk);
    check_eq("single_req_count", req_cnt, 1);
    check_eq("single_out_count", deliv_cnt, 1);

    // Enable drop: in-flight word still delivered, no further requests.
    do_reset();
    @(posedge clk); #2;
    for (int i = 0; i < 10; i++) push_word(DW'(8'h40 + i));
    repeat (3) @(posedge clk);
    #2 en = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("en_low_req_count", req_cnt, 3);
    check_eq("en_low_delivered", deliv_cnt, 3);
    check_eq("en_low_busy", busy, 0);
    @(posedge clk); #2 en = 1'b1;
    wait_drain(40);

    // Asynchronous reset with two words buffered.
    do_reset();
    rmode = 3;
    @(posedge clk); #2;
    push_word(8'h91);
    push_word(8'h92);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("pre_rst_level", level_q, 2);
    check_eq("pre_rst_valid", m_valid, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    clear_model();
    #1;
    check_eq("async_rst_valid", m_valid, 0);
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_req", req, 0);
    check_eq("async_rst_data", m_data, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    rmode = 0;
    // Burst position restarts: the fourth word after reset is last.
    @(posedge clk); #2;
    for (int i = 0; i < 6; i++) push_word(DW'(8'hA0 + i));
    wait_drain(40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
